inv_round: RTL and testbench

Single pipelined AES inverse-cipher round for the decryption datapath: InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, one register stage per transform. It mirrors the encryption round's valid-based interface, so the decrypt controller chains ten instances, or iterates one, with the key schedule supplied in reverse order. It accepts one 128-bit beat per clock and applies no backpressure.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/inv_mix_column.sv | 21 ++
 rtl/inv_round.sv | 104 ++++++++++
 tb/tb_inv_round.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: inverse S-box, GF(2^8) constant multipliers and
// the InvShiftRows byte mapping (byte 0 is the MSB, column-major).
package aes_pkg;

   localparam int DATA_W = 128;

   localparam logic [0:255][7:0] INV_SBOX_TBL = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX_TBL[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // 9 = x^3+1, 11 = x^3+x+1, 13 = x^3+x^2+1, 14 = x^3+x^2+x
   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // Source byte index feeding output byte i: row r rotates right by r columns.
   function automatic int inv_shift_src(input int i);
      int r;
      int c;
      r = i % 4;
      c = i / 4;
      return 4 * ((c - r + 4) % 4) + r;
   endfunction

endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns on one 32-bit column (row 0 in the MSB byte); purely combinational.
module inv_mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   assign col_out[31:24] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
   assign col_out[23:16] = gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
   assign col_out[15:8]  = gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3);
   assign col_out[7:0]   = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3);

endmodule

// File: rtl/inv_round.sv
// AES inverse round, 4 register stages (out valid 3 edges after accept), no backpressure.
// INV_ROUND_FINAL_EN adds final_round, which bypasses InvMixColumns for that beat.
module inv_round
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              data_valid_in,
   input  logic              key_valid_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] round_key,
`ifdef INV_ROUND_FINAL_EN
   input  logic              final_round,
`endif
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] key_q;
   logic [DATA_W-1:0] beat_key;
   logic [DATA_W-1:0] shift_nxt;
   logic [DATA_W-1:0] sub_nxt;
   logic [DATA_W-1:0] mix_dat;
   logic [DATA_W-1:0] out_nxt;

   logic              valid_shift_to_sub;
   logic              valid_sub_to_addkey;
   logic              valid_addkey_to_mix;
   logic [DATA_W-1:0] shift_dat, shift_key;
   logic [DATA_W-1:0] sub_dat, sub_key;
   logic [DATA_W-1:0] addkey_dat;

   // A key arriving with the beat wins over the held key.
   assign beat_key = key_valid_in ? round_key : key_q;

   for (genvar i = 0; i < 16; i++) begin : g_bytes
      localparam int SRC = inv_shift_src(i);
      assign shift_nxt[DATA_W-1-8*i -: 8] = data_in[DATA_W-1-8*SRC -: 8];
      assign sub_nxt[DATA_W-1-8*i -: 8]   = inv_sbox(shift_dat[DATA_W-1-8*i -: 8]);
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      inv_mix_column u_mix (
         .col_in  (addkey_dat[DATA_W-1-32*c -: 32]),
         .col_out (mix_dat[DATA_W-1-32*c -: 32])
      );
   end

`ifdef INV_ROUND_FINAL_EN
   logic shift_fin, sub_fin, addkey_fin;

   assign out_nxt = addkey_fin ? addkey_dat : mix_dat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_fin  <= 1'b0;
         sub_fin    <= 1'b0;
         addkey_fin <= 1'b0;
      end else begin
         if (data_valid_in)       shift_fin  <= final_round;
         if (valid_shift_to_sub)  sub_fin    <= shift_fin;
         if (valid_sub_to_addkey) addkey_fin <= sub_fin;
      end
   end
`else
   assign out_nxt = mix_dat;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_q               <= '0;
         valid_shift_to_sub  <= 1'b0;
         valid_sub_to_addkey <= 1'b0;
         valid_addkey_to_mix <= 1'b0;
         valid_out           <= 1'b0;
         shift_dat           <= '0;
         shift_key           <= '0;
         sub_dat             <= '0;
         sub_key             <= '0;
         addkey_dat          <= '0;
         data_out            <= '0;
      end else begin
         if (key_valid_in) key_q <= round_key;

         valid_shift_to_sub  <= data_valid_in;
         valid_sub_to_addkey <= valid_shift_to_sub;
         valid_addkey_to_mix <= valid_sub_to_addkey;
         valid_out           <= valid_addkey_to_mix;

         // Each beat carries its own key so later key loads cannot disturb it.
         if (data_valid_in) begin
            shift_dat <= shift_nxt;
            shift_key <= beat_key;
         end
         if (valid_shift_to_sub) begin
            sub_dat <= sub_nxt;
            sub_key <= shift_key;
         end
         if (valid_sub_to_addkey) addkey_dat <= sub_dat ^ sub_key;
         if (valid_addkey_to_mix) data_out   <= out_nxt;
      end
   end

endmodule

// File: tb/tb_inv_round.sv
// Self-checking bench for inv_round: directed FIPS-197 vectors plus random beats
// scored against a GF(2^8)-arithmetic model of the inverse round.
module tb_inv_round;

   logic         clk;
   logic         reset;
   logic         data_valid_in;
   logic         key_valid_in;
   logic [127:0] data_in;
   logic [127:0] round_key;
`ifdef INV_ROUND_FINAL_EN
   logic         final_round;
`endif
   logic         valid_out;
   logic [127:0] data_out;

   inv_round dut (
      .clk           (clk),
      .reset         (reset),
      .data_valid_in (data_valid_in),
      .key_valid_in  (key_valid_in),
      .data_in       (data_in),
      .round_key     (round_key),
`ifdef INV_ROUND_FINAL_EN
      .final_round   (final_round),
`endif
      .valid_out     (valid_out),
      .data_out      (data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int           due;
      logic [127:0] dat;
   } exp_t;

   exp_t         exp_q[$];
   logic [7:0]   inv_sb[256];
   logic [127:0] key_m;
   logic [127:0] last_out;
   int           edge_n;
   int           n_cmp;
   int           n_bad;

   localparam logic [127:0] D1  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
   localparam logic [127:0] K1  = 128'h549932d1f08557681093ed9cbe2c974e;
   localparam logic [127:0] E1  = 128'h54d990a16ba09ab596bbf40ea111702f;
   localparam logic [127:0] S1  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
   localparam logic [127:0] S2  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
   localparam logic [127:0] DF  = 128'h6353e08c0960e104cd70b751bacad0e7;
   localparam logic [127:0] KF  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] EF  = 128'h00112233445566778899aabbccddeeff;

   // ---------------- reference model: plain field arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [8:0] t;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         t = {a, 1'b0};
         a = t[8] ? (t[7:0] ^ 8'h1b) : t[7:0];
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] w;
      w = {b, b} << n;
      return w[15:8];
   endfunction

   // Forward S-box = affine(b^254); the inverse table is its reversal.
   function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, x);
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                              input logic fin);
      logic [7:0]   st[4][4];
      logic [7:0]   t[4][4];
      logic [7:0]   coef[4];
      logic [7:0]   acc;
      logic [127:0] o;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = d[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][(c+r)%4] = inv_sb[st[r][c]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[r][c] = t[r][c] ^ k[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], t[j][c]);
            o[127-8*(4*c+r) -: 8] = fin ? t[r][c] : acc;
         end
      return o;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
         chk("valid_out_hi", {127'd0, valid_out}, 128'd1);
         chk("data_out", data_out, exp_q[0].dat);
         last_out = exp_q[0].dat;
         void'(exp_q.pop_front());
      end else begin
         chk("valid_out_lo", {127'd0, valid_out}, 128'd0);
         chk("data_out_hold", data_out, last_out);
      end
   endtask

   // One clock: drive at negedge, model the accepting edge, check at next negedge.
   task automatic drive(input logic dv, input logic kv, input logic [127:0] d,
                        input logic [127:0] k, input logic fin,
                        input logic has_exp, input logic [127:0] exp_d);
      logic         fin_eff;
      logic [127:0] bk;
`ifdef INV_ROUND_FINAL_EN
      fin_eff     = fin;
      final_round = fin;
`else
      fin_eff     = 1'b0 & fin;
`endif
      data_valid_in = dv;
      key_valid_in  = kv;
      data_in       = d;
      round_key     = k;
      @(posedge clk);
      edge_n++;
      bk = kv ? k : key_m;
      if (dv) exp_q.push_back('{edge_n + 3, has_exp ? exp_d : ref_round(d, bk, fin_eff)});
      if (kv) key_m = k;
      @(negedge clk);
      check_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 128'd0, 128'd0, 1'b0, 1'b0, 128'd0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_reset(input int n);
      reset = 1'b0;
      exp_q.delete();
      key_m    = '0;
      last_out = '0;
      #1;
      chk("rst_valid", {127'd0, valid_out}, 128'd0);
      chk("rst_data", data_out, 128'd0);
      for (int i = 0; i < n; i++) begin
         data_valid_in = 1'($urandom);
         key_valid_in  = 1'($urandom);
         data_in       = rnd128();
         round_key     = rnd128();
         @(posedge clk);
         edge_n++;
         @(negedge clk);
         chk("rst_valid", {127'd0, valid_out}, 128'd0);
         chk("rst_data", data_out, 128'd0);
      end
      data_valid_in = 1'b0;
      key_valid_in  = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      edge_n = 0;
      reset = 1'b0;
      data_valid_in = 1'b0;
      key_valid_in  = 1'b0;
      data_in   = '0;
      round_key = '0;
`ifdef INV_ROUND_FINAL_EN
      final_round = 1'b0;
`endif
      for (int x = 0; x < 256; x++) inv_sb[fwd_sbox(8'(x))] = 8'(x);

      @(negedge clk);
      do_reset(2);

      // FIPS-197 C.1 round 1, plus internal stage checks
      drive(1'b1, 1'b1, D1, K1, 1'b0, 1'b1, E1);
      chk("stage1", dut.shift_dat, S1);
      idle(1);
      chk("stage2", dut.sub_dat, S2);
      idle(4);

      // Held key: load a different key, then K1, then data alone
      drive(1'b0, 1'b1, 128'd0, rnd128(), 1'b0, 1'b0, 128'd0);
      drive(1'b0, 1'b1, 128'd0, K1, 1'b0, 1'b0, 128'd0);
      idle(2);
      drive(1'b1, 1'b0, D1, rnd128(), 1'b0, 1'b1, E1);
      idle(4);

      // Key change while a beat is in flight
      drive(1'b1, 1'b1, D1, K1, 1'b0, 1'b1, E1);
      drive(1'b0, 1'b1, 128'd0, rnd128(), 1'b0, 1'b0, 128'd0);
      idle(4);

      // Back-to-back beats, middle one with key 0
      drive(1'b1, 1'b1, D1, K1, 1'b0, 1'b1, E1);
      drive(1'b1, 1'b1, D1, 128'd0, 1'b0, 1'b0, 128'd0);
      drive(1'b1, 1'b1, D1, K1, 1'b0, 1'b1, E1);
      idle(4);

`ifdef INV_ROUND_FINAL_EN
      drive(1'b1, 1'b1, DF, KF, 1'b1, 1'b1, EF);
      idle(4);
`endif

      // Reset one edge after accepting a beat: nothing must emerge
      drive(1'b1, 1'b1, D1, K1, 1'b0, 1'b1, E1);
      do_reset(1);
      idle(6);

      // Beat with no key ever loaded uses key 0
      drive(1'b1, 1'b0, D1, K1, 1'b0, 1'b0, 128'd0);
      idle(4);

      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               rnd128(), rnd128(), 1'($urandom), 1'b0, 128'd0);
      idle(5);

      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
